// File: rtl/core_types_pkg.sv
// Shared core types for the ALU reservation station: tags, ops, entry layout,
// and the ROB age helper used for restore-point kills.
package core_types_pkg;

    localparam int unsigned ALU_RS_DEPTH  = 4;
    localparam int unsigned NUM_WB_BUS    = 2;
    localparam int unsigned LOG_ROB_DEPTH = 4;
    localparam int unsigned LOG_PR_COUNT  = 6;

    typedef logic [LOG_PR_COUNT-1:0]  phys_reg_tag_t;
    typedef logic [15:0]              imm16_t;
    typedef logic [LOG_ROB_DEPTH:0]   ROB_index_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } ALU_op_t;

    typedef struct packed {
        logic          needed;
        logic          ready;
        phys_reg_tag_t phys_reg_tag;
    } source_reg_status_t;

    typedef struct packed {
        ALU_op_t            op;
        logic               itype;
        source_reg_status_t source_0;
        source_reg_status_t source_1;
        phys_reg_tag_t      dest_phys_reg_tag;
        imm16_t             imm16;
        ROB_index_t         ROB_index;
    } ALU_RS_input_struct_t;

    typedef struct packed {
        logic               valid;
        ALU_op_t            op;
        logic               itype;
        source_reg_status_t source_0;
        source_reg_status_t source_1;
        phys_reg_tag_t      dest_phys_reg_tag;
        imm16_t             imm16;
        ROB_index_t         ROB_index;
    } ALU_RS_entry_t;

    // Distance from the ROB head; wraps modulo 2^(LOG_ROB_DEPTH+1).
    function automatic ROB_index_t rob_age(input ROB_index_t index, input ROB_index_t head);
        return index - head;
    endfunction

endpackage

// File: rtl/alu_rs_wakeup_cam.sv
// Single-source wakeup compare: the source becomes ready if any valid
// writeback bus broadcasts the tag it is waiting on.
module alu_rs_wakeup_cam
    import core_types_pkg::*;
(
    input  source_reg_status_t                   source,
    input  logic [NUM_WB_BUS-1:0]                WB_bus_valid,
    input  phys_reg_tag_t [NUM_WB_BUS-1:0]       WB_bus_phys_reg_tag,
    output logic                                 next_ready
);

    always_comb begin
        next_ready = source.ready;
        for (int unsigned b = 0; b < NUM_WB_BUS; b++) begin
            if (source.needed && WB_bus_valid[b] &&
                (WB_bus_phys_reg_tag[b] == source.phys_reg_tag)) begin
                next_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Collapsing-queue ALU reservation station: tag wakeup, oldest-ready issue,
// and age-based kill on ROB restore. Entry 0 is always the oldest.
module alu_reservation_station
    import core_types_pkg::*;
(
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           dispatch_valid,
    input  ALU_RS_input_struct_t           dispatch_struct,
    output logic                           dispatch_ready,
    input  logic [NUM_WB_BUS-1:0]          WB_bus_valid,
    input  phys_reg_tag_t [NUM_WB_BUS-1:0] WB_bus_phys_reg_tag,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output ALU_op_t                        issue_op,
    output logic                           issue_itype,
    output phys_reg_tag_t                  issue_source_0_phys_reg_tag,
    output phys_reg_tag_t                  issue_source_1_phys_reg_tag,
    output phys_reg_tag_t                  issue_dest_phys_reg_tag,
    output imm16_t                         issue_imm16,
    output ROB_index_t                     issue_ROB_index,
    input  logic                           kill_valid,
    input  ROB_index_t                     kill_ROB_index,
    input  ROB_index_t                     ROB_head_index
);

    localparam int unsigned NCAM = ALU_RS_DEPTH + 1;

    ALU_RS_entry_t      entries [ALU_RS_DEPTH];
    ALU_RS_entry_t      nxt     [ALU_RS_DEPTH];
    ALU_RS_entry_t      woken   [NCAM];
    ALU_RS_entry_t      disp_entry;
    logic [ALU_RS_DEPTH:0] keep;

    // CAM slot ALU_RS_DEPTH compares the incoming dispatch sources.
    source_reg_status_t cam_src0 [NCAM];
    source_reg_status_t cam_src1 [NCAM];
    logic [NCAM-1:0]    next_ready0;
    logic [NCAM-1:0]    next_ready1;

    always_comb begin
        for (int unsigned i = 0; i < ALU_RS_DEPTH; i++) begin
            cam_src0[i] = entries[i].source_0;
            cam_src1[i] = entries[i].source_1;
        end
        cam_src0[ALU_RS_DEPTH] = dispatch_struct.source_0;
        cam_src1[ALU_RS_DEPTH] = dispatch_struct.source_1;
    end

    for (genvar g = 0; g < NCAM; g++) begin : g_cam
        alu_rs_wakeup_cam u_cam0 (
            .source              (cam_src0[g]),
            .WB_bus_valid        (WB_bus_valid),
            .WB_bus_phys_reg_tag (WB_bus_phys_reg_tag),
            .next_ready          (next_ready0[g])
        );
        alu_rs_wakeup_cam u_cam1 (
            .source              (cam_src1[g]),
            .WB_bus_valid        (WB_bus_valid),
            .WB_bus_phys_reg_tag (WB_bus_phys_reg_tag),
            .next_ready          (next_ready1[g])
        );
    end

    logic                  sel_found;
    logic [ALU_RS_DEPTH-1:0] sel_oh;
    ALU_op_t               sel_op;
    logic                  sel_itype;
    phys_reg_tag_t         sel_src0_tag;
    phys_reg_tag_t         sel_src1_tag;
    phys_reg_tag_t         sel_dest;
    imm16_t                sel_imm;
    ROB_index_t            sel_rob;
    ROB_index_t            kill_age;
    logic                  sel_killed;
    logic                  issue_fire;
    logic                  dispatch_fire;

    // Select on registered readiness, so a wakeup only counts from the next cycle.
    always_comb begin
        logic rdy;
        rdy          = 1'b0;
        sel_found    = 1'b0;
        sel_oh       = '0;
        sel_op       = ALU_ADD;
        sel_itype    = 1'b0;
        sel_src0_tag = '0;
        sel_src1_tag = '0;
        sel_dest     = '0;
        sel_imm      = '0;
        sel_rob      = '0;
        for (int unsigned i = 0; i < ALU_RS_DEPTH; i++) begin
            rdy = entries[i].valid &&
                  (!entries[i].source_0.needed || entries[i].source_0.ready) &&
                  (!entries[i].source_1.needed || entries[i].source_1.ready);
            if (rdy && !sel_found) begin
                sel_found    = 1'b1;
                sel_oh[i]    = 1'b1;
                sel_op       = entries[i].op;
                sel_itype    = entries[i].itype;
                sel_src0_tag = entries[i].source_0.phys_reg_tag;
                sel_src1_tag = entries[i].source_1.phys_reg_tag;
                sel_dest     = entries[i].dest_phys_reg_tag;
                sel_imm      = entries[i].imm16;
                sel_rob      = entries[i].ROB_index;
            end
        end
    end

    assign kill_age       = rob_age(kill_ROB_index, ROB_head_index);
    assign sel_killed     = kill_valid && (rob_age(sel_rob, ROB_head_index) >= kill_age);
    assign issue_valid    = sel_found && !sel_killed;
    assign issue_fire     = issue_valid && issue_ready;
    assign dispatch_ready = !entries[ALU_RS_DEPTH-1].valid && !kill_valid;
    assign dispatch_fire  = dispatch_valid && dispatch_ready;

    assign issue_op                    = issue_valid ? sel_op       : ALU_ADD;
    assign issue_itype                 = issue_valid ? sel_itype    : 1'b0;
    assign issue_source_0_phys_reg_tag = issue_valid ? sel_src0_tag : '0;
    assign issue_source_1_phys_reg_tag = issue_valid ? sel_src1_tag : '0;
    assign issue_dest_phys_reg_tag     = issue_valid ? sel_dest     : '0;
    assign issue_imm16                 = issue_valid ? sel_imm      : '0;
    assign issue_ROB_index             = issue_valid ? sel_rob      : '0;

    always_comb begin
        disp_entry                   = '0;
        disp_entry.valid             = 1'b1;
        disp_entry.op                = dispatch_struct.op;
        disp_entry.itype             = dispatch_struct.itype;
        disp_entry.source_0          = dispatch_struct.source_0;
        disp_entry.source_1          = dispatch_struct.source_1;
        disp_entry.source_0.ready    = next_ready0[ALU_RS_DEPTH];
        disp_entry.source_1.ready    = next_ready1[ALU_RS_DEPTH];
        disp_entry.dest_phys_reg_tag = dispatch_struct.dest_phys_reg_tag;
        disp_entry.imm16             = dispatch_struct.imm16;
        disp_entry.ROB_index         = dispatch_struct.ROB_index;
    end

    // Killed entries are always a younger suffix, so one shift past the issued
    // slot keeps the queue dense; dispatch lands in the first free slot after it.
    always_comb begin
        logic shifting;
        logic placed;
        shifting = 1'b0;
        placed   = 1'b0;
        for (int unsigned i = 0; i < ALU_RS_DEPTH; i++) begin
            woken[i]                = entries[i];
            woken[i].source_0.ready = next_ready0[i];
            woken[i].source_1.ready = next_ready1[i];
            keep[i] = entries[i].valid &&
                      !(kill_valid && (rob_age(entries[i].ROB_index, ROB_head_index) >= kill_age)) &&
                      !(issue_fire && sel_oh[i]);
        end
        woken[ALU_RS_DEPTH] = '0;
        keep[ALU_RS_DEPTH]  = 1'b0;
        for (int unsigned i = 0; i < ALU_RS_DEPTH; i++) begin
            shifting = shifting || (issue_fire && sel_oh[i]);
            if (shifting) begin
                nxt[i] = keep[i+1] ? woken[i+1] : '0;
            end else begin
                nxt[i] = keep[i] ? woken[i] : '0;
            end
            if (!nxt[i].valid && dispatch_fire && !placed) begin
                nxt[i] = disp_entry;
                placed = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ALU_RS_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ALU_RS_DEPTH; i++) begin
                entries[i] <= nxt[i];
            end
        end
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Holds renamed ALU instructions between dispatch and the ALU pipeline.
- Accepts one ALU_RS_input_struct_t per cycle from dispatch.
- Tracks source readiness by snooping the writeback tag buses, then issues the oldest fully-ready entry to the ALU.
- Supports selective kill of younger-than-restore-point entries when the ROB restores after a mispredict.

Parameters:
- ALU_RS_DEPTH, 4, number of entries (collapsing queue; entry 0 oldest).
- NUM_WB_BUS, 2, number of writeback tag broadcast buses snooped for wakeup.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- dispatch_valid  in  1  dispatch presents an instruction.
- dispatch_struct  in  ALU_RS_input_struct_t  op, itype, source_0/1 status, dest tag, imm16, ROB_index.
- dispatch_ready  out  1  RS can accept this cycle.
- WB_bus_valid  in  NUM_WB_BUS  per-bus broadcast valid.
- WB_bus_phys_reg_tag  in  NUM_WB_BUS x phys_reg_tag_t  per-bus produced tag.
- issue_valid  out  1  issue fields valid.
- issue_ready  in  1  ALU pipeline accepts this cycle.
- issue_op  out  ALU_op_t  issued op.
- issue_itype  out  1  issued itype.
- issue_source_0_phys_reg_tag  out  phys_reg_tag_t  source 0 tag for regfile read.
- issue_source_1_phys_reg_tag  out  phys_reg_tag_t  source 1 tag for regfile read.
- issue_dest_phys_reg_tag  out  phys_reg_tag_t  destination tag.
- issue_imm16  out  imm16_t  immediate.
- issue_ROB_index  out  ROB_index_t  ROB index.
- kill_valid  in  1  ROB restore kill request.
- kill_ROB_index  in  ROB_index_t  oldest ROB index to kill (inclusive).
- ROB_head_index  in  ROB_index_t  current ROB head, used for age compare.

Behaviour:
- Reset (nRST low, asynchronous): all entry valid bits 0, count 0.
- Reset outputs: dispatch_ready 1, issue_valid 0, all issue_* fields 0.
- Entry contents: valid, op, itype, src0/src1 {needed, ready, tag}, dest tag, imm16, ROB_index.
- Source readiness: a source counts as ready if needed==0 or ready==1.
- Entry readiness: an entry is ready when both sources are ready.
- Wakeup: each cycle, any valid entry source with needed==1 whose tag matches any WB_bus with valid=1 sets ready=1 at the next edge.
- Dispatch-cycle wakeup: dispatched sources also compare against the same-cycle WB buses, so the entry is written already-ready.
- dispatch_ready = (count < ALU_RS_DEPTH) && !kill_valid. Full-with-simultaneous-issue does not allow dispatch; no bypass.
- Dispatch handshake: on dispatch_valid && dispatch_ready, the entry is written at index count, after compaction for any same-cycle issue.
- Minimum residency is 1 cycle; no same-cycle dispatch-to-issue.
- Select is combinational: the lowest-index valid ready entry, so the oldest wins.
- issue_valid = a selected entry exists && it is not killed this cycle. issue_* fields are driven from that entry.
- Issue handshake: on issue_valid && issue_ready the entry is removed. Younger entries shift down one slot at the edge, preserving order, and their wakeup results this cycle are retained through the shift.
- Backpressure: if issue_ready==0, the entry stays. Select may change next cycle if an older entry becomes ready.
- Kill: age(x) = (x - ROB_head_index) mod 2^(LOG_ROB_DEPTH+1). Any entry with age(entry.ROB_index) >= age(kill_ROB_index) is invalidated at the edge.
- Kill compaction: survivors are always the older prefix, so count becomes the survivor count and no holes appear.
- Kill is exclusive: during kill_valid, dispatch is blocked, and an issue of a surviving entry still proceeds normally.
- Empty: issue_valid=0. Full: dispatch_ready=0.
- Duplicate ROB indices are never presented; the bench does not check behaviour in that case.

Decomposition:
- ALU_RS_DEPTH, NUM_WB_BUS and an ALU_RS_entry_t struct go in core_types_pkg.
- The struct fields are: valid, ALU_op_t op, itype, source_reg_status_t source_0/1, dest tag, imm16, ROB_index.
- ROB age compare becomes a package function rob_age(index, head).
- The natural sub-module is alu_rs_wakeup_cam: per-entry, per-source tag compare against the WB buses, returning a next-ready bit.

Test Plan:
- Reset, then dispatch ADD with src0 tag 5 ready and src1 not needed, issue_ready=1 -> issue_valid rises next cycle with dest/tags/ROB_index matching; count returns to 0.
- Dispatch SUB with src0 tag 12 not ready; WB_bus[1] broadcasts tag 12 two cycles later -> issue_valid only on the cycle after the broadcast.
- Dispatch at the same cycle WB_bus[0] broadcasts the needed tag 7 -> entry ready immediately; issues the next cycle.
- Fill 4 entries with none ready -> dispatch_ready=0. Wake entries 2 and 0 in the same cycle -> entry 0 issues first, then old entry 2 issues from slot 1.
- ROB_head=30, entries with ROB_index 30, 31, 0, 1; kill_valid with kill_ROB_index=0 -> only 30 and 31 survive, count=2, dispatch_ready=0 during kill.
- Hold issue_ready=0 for 3 cycles with a ready entry -> issue fields stable, no removal; then issue_ready=1 -> removed in 1 cycle. Assert nRST mid-stream -> issue_valid=0 immediately, asynchronously.
